id_rd_lmsm_reg: RTL and testbench
=================================

ID_RD_LMSM_REG -- requirements
Module: id_rd_lmsm_reg

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 instr_id  in  16  decoded-stage instruction word; opcode = instr_id[15:12], register mask = instr_id[7:0].
REQ-003 pc_id, npc_id  in  16 each  PC and PC+1 of instr_id.
REQ-004 valid_id  in  1  instr_id holds a real instruction.
REQ-005 stall_rd  in  1  downstream hazard stall; hold the RD-side register.
REQ-006 flush  in  1  branch/jump redirect; kill the RD-side contents.
REQ-007 instr_rd, pc_rd, npc_rd  out  16 each  registered instruction, PC and next PC to register-read.
REQ-008 valid_rd  out  1  the RD-side register holds a live micro-op.
REQ-009 lmsm_rd  out  1  the current micro-op belongs to an LM (0110) or SM (0111).
REQ-010 lmsm_reg_rd  out  3  register index for the current LM/SM micro-op.
REQ-011 lmsm_off_rd  out  3  word offset from the base address: 0 for the first micro-op, +1 per micro-op.
REQ-012 lmsm_last_rd  out  1  the current micro-op is the final one of its LM/SM.
REQ-013 stall_id  out  1  combinational; hold the IF/ID register and the PC.

Function
REQ-014 States: IDLE, SEQ; the internal 8-bit remaining-mask register rem holds the LM/SM bits not yet issued.
REQ-015 stall_id SHALL equal stall_rd OR (state==SEQ).
REQ-016 When stall_rd=1 and flush=0, all outputs, state and rem SHALL hold their values.
REQ-017 In IDLE with stall_rd=0, valid_id=0: valid_rd<=0 and lmsm_rd<=0; the other data outputs are don't-care.
REQ-018 In IDLE with stall_rd=0, valid_id=1 and a non-LM/SM opcode: instr/pc/npc are copied; valid_rd<=1, lmsm_rd<=0, lmsm_reg_rd<=0, lmsm_off_rd<=0, lmsm_last_rd<=0; latency is 1 cycle.
REQ-019 Mask bit i selects register Ri; issue order is ascending index (lowest set bit first).
REQ-020 In IDLE with an LM/SM and mask==0: the instruction is consumed as a bubble; valid_rd<=0, and the state stays IDLE.
REQ-021 In IDLE with an LM/SM and exactly one mask bit set: one micro-op is issued (valid_rd=1, lmsm_rd=1, reg = that index, off=0, last=1), and the state stays IDLE.
REQ-022 In IDLE with an LM/SM and two or more mask bits set: the first micro-op is issued (lowest index, off=0, last=0); instr/pc/npc are latched; rem<=mask with the lowest bit cleared; state goes to SEQ.
REQ-023 In SEQ with stall_rd=0, each cycle SHALL issue the next micro-op:
  - reg = lowest set bit of rem;
  - off = previous off+1;
  - instr/pc/npc unchanged;
  - that bit is cleared from rem.
REQ-024 In SEQ, when rem has exactly one bit set, that micro-op SHALL carry last=1 and the state SHALL return to IDLE.
REQ-025 An LM/SM with n set bits SHALL occupy exactly n non-stalled output cycles; stall_id is high for n-1 non-stalled cycles; off never exceeds 7 (no wrap).
REQ-026 The block SHALL not sample instr_id while in SEQ; the instruction following the LM/SM is accepted in the first non-stalled IDLE cycle.
REQ-027 flush=1 SHALL set valid_rd<=0, lmsm_rd<=0, lmsm_last_rd<=0, rem<=0 and state<=IDLE, with priority over stall_rd and over any issue.

Reset
REQ-028 rst=1 at a clock edge SHALL have priority over flush and stall_rd.
REQ-029 On reset, all outputs SHALL be cleared to 0, rem<=0 and state<=IDLE, including when reset arrives mid-sequence.
REQ-030 stall_id SHALL equal 0 after reset, provided stall_rd=0.

Verification
REQ-031 Input ADD (0x0000 class) at pc 0x0010, valid_id=1 -> next cycle: valid_rd=1, pc_rd=0x0010, npc_rd=0x0011, lmsm_rd=0, stall_id=0.
REQ-032 Input LM, mask 0x29 (R0, R3, R5) -> three consecutive outputs with reg/off/last of 0/0/0, 3/1/0, 5/2/1; stall_id=1 for 2 cycles; the next instruction appears on the 4th cycle.
REQ-033 Input SM, mask 0x00 -> valid_rd=0 for one cycle and stall_id=0; input SM, mask 0x80 -> single micro-op with reg=7, off=0, last=1.
REQ-034 Input LM, mask 0xFF with stall_rd=1 for 2 cycles after the 3rd micro-op -> outputs hold for those 2 cycles; the sequence then resumes reg=3..7, off=3..7; total of 8 issued micro-ops.
REQ-035 Input LM, mask 0x0F, with flush on the 2nd micro-op cycle -> valid_rd=0 and state IDLE next cycle, stall_id=0, and no further micro-ops.
REQ-036 Input LM, mask 0x0F, with rst on the 2nd micro-op cycle -> all outputs 0 and IDLE next cycle, even if stall_rd=1 and flush=1 in the same cycle.

Source files
------------

// File: rtl/id_rd_lmsm_reg.sv
// id_rd_lmsm_reg: ID->RD pipeline register that splits LM/SM into one micro-op per mask bit.
// Ports: clk, rst (sync, active-high); instr/pc/npc/valid_id in; stall_rd, flush; *_rd out; stall_id out.
module id_rd_lmsm_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr_id,
   input  logic [15:0] pc_id,
   input  logic [15:0] npc_id,
   input  logic        valid_id,
   input  logic        stall_rd,
   input  logic        flush,
   output logic [15:0] instr_rd,
   output logic [15:0] pc_rd,
   output logic [15:0] npc_rd,
   output logic        valid_rd,
   output logic        lmsm_rd,
   output logic [2:0]  lmsm_reg_rd,
   output logic [2:0]  lmsm_off_rd,
   output logic        lmsm_last_rd,
   output logic        stall_id
);

   typedef enum logic {IDLE, SEQ} state_t;

   state_t      state, state_nxt;
   logic [7:0]  rem, rem_nxt;
   logic [15:0] instr_nxt, pc_nxt, npc_nxt;
   logic        valid_nxt, lmsm_nxt, last_nxt;
   logic [2:0]  reg_nxt, off_nxt;

   logic        is_lmsm;
   logic [7:0]  src;
   logic [7:0]  src_rest;
   logic [2:0]  low;
   logic        single;

   function automatic logic [2:0] low_idx(input logic [7:0] m);
      low_idx = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) low_idx = 3'(i);
   endfunction

   // LM = 0110, SM = 0111
   assign is_lmsm  = (instr_id[15:13] == 3'b011);
   // In SEQ the pending bits come from rem, never from instr_id
   assign src      = (state == SEQ) ? rem : instr_id[7:0];
   assign low      = low_idx(src);
   // x & (x-1) drops the lowest set bit
   assign src_rest = src & (src - 8'd1);
   assign single   = (src != 8'd0) && (src_rest == 8'd0);

   assign stall_id = stall_rd | (state == SEQ);

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      instr_nxt = instr_rd;
      pc_nxt    = pc_rd;
      npc_nxt   = npc_rd;
      valid_nxt = valid_rd;
      lmsm_nxt  = lmsm_rd;
      reg_nxt   = lmsm_reg_rd;
      off_nxt   = lmsm_off_rd;
      last_nxt  = lmsm_last_rd;
      if (flush) begin
         valid_nxt = 1'b0;
         lmsm_nxt  = 1'b0;
         last_nxt  = 1'b0;
         rem_nxt   = 8'd0;
         state_nxt = IDLE;
      end else if (!stall_rd) begin
         unique case (state)
            IDLE: begin
               if (!valid_id) begin
                  valid_nxt = 1'b0;
                  lmsm_nxt  = 1'b0;
               end else if (!is_lmsm) begin
                  instr_nxt = instr_id;
                  pc_nxt    = pc_id;
                  npc_nxt   = npc_id;
                  valid_nxt = 1'b1;
                  lmsm_nxt  = 1'b0;
                  reg_nxt   = 3'd0;
                  off_nxt   = 3'd0;
                  last_nxt  = 1'b0;
               end else if (instr_id[7:0] == 8'd0) begin
                  // Empty mask: swallow the instruction as a bubble
                  valid_nxt = 1'b0;
                  lmsm_nxt  = 1'b0;
                  last_nxt  = 1'b0;
               end else begin
                  instr_nxt = instr_id;
                  pc_nxt    = pc_id;
                  npc_nxt   = npc_id;
                  valid_nxt = 1'b1;
                  lmsm_nxt  = 1'b1;
                  reg_nxt   = low;
                  off_nxt   = 3'd0;
                  last_nxt  = single;
                  rem_nxt   = src_rest;
                  state_nxt = single ? IDLE : SEQ;
               end
            end
            SEQ: begin
               valid_nxt = 1'b1;
               lmsm_nxt  = 1'b1;
               reg_nxt   = low;
               off_nxt   = lmsm_off_rd + 3'd1;
               last_nxt  = single;
               rem_nxt   = src_rest;
               state_nxt = single ? IDLE : SEQ;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rem          <= 8'd0;
         instr_rd     <= 16'd0;
         pc_rd        <= 16'd0;
         npc_rd       <= 16'd0;
         valid_rd     <= 1'b0;
         lmsm_rd      <= 1'b0;
         lmsm_reg_rd  <= 3'd0;
         lmsm_off_rd  <= 3'd0;
         lmsm_last_rd <= 1'b0;
      end else begin
         state        <= state_nxt;
         rem          <= rem_nxt;
         instr_rd     <= instr_nxt;
         pc_rd        <= pc_nxt;
         npc_rd       <= npc_nxt;
         valid_rd     <= valid_nxt;
         lmsm_rd      <= lmsm_nxt;
         lmsm_reg_rd  <= reg_nxt;
         lmsm_off_rd  <= off_nxt;
         lmsm_last_rd <= last_nxt;
      end
   end

endmodule

// File: tb/tb_id_rd_lmsm_reg.sv
// tb_id_rd_lmsm_reg: directed self-checking bench for id_rd_lmsm_reg.
// Drives vectors 1 ns after each rising edge and checks outputs there.
module tb_id_rd_lmsm_reg;

   logic        clk = 1'b0;
   logic        rst, valid_id, stall_rd, flush;
   logic [15:0] instr_id, pc_id, npc_id;
   logic [15:0] instr_rd, pc_rd, npc_rd;
   logic        valid_rd, lmsm_rd, lmsm_last_rd, stall_id;
   logic [2:0]  lmsm_reg_rd, lmsm_off_rd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_rd_lmsm_reg dut (
      .clk(clk), .rst(rst),
      .instr_id(instr_id), .pc_id(pc_id), .npc_id(npc_id),
      .valid_id(valid_id), .stall_rd(stall_rd), .flush(flush),
      .instr_rd(instr_rd), .pc_rd(pc_rd), .npc_rd(npc_rd),
      .valid_rd(valid_rd), .lmsm_rd(lmsm_rd),
      .lmsm_reg_rd(lmsm_reg_rd), .lmsm_off_rd(lmsm_off_rd),
      .lmsm_last_rd(lmsm_last_rd), .stall_id(stall_id)
   );

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] i, input logic [15:0] pc,
                        input logic v);
      instr_id = i;
      pc_id    = pc;
      npc_id   = pc + 16'd1;
      valid_id = v;
   endtask

   task automatic chk_uop(input string tag, input logic [2:0] r,
                          input logic [2:0] o, input logic l,
                          input logic sid);
      chk({tag, ".valid"}, 16'(valid_rd), 16'd1);
      chk({tag, ".lmsm"}, 16'(lmsm_rd), 16'd1);
      chk({tag, ".reg"}, 16'(lmsm_reg_rd), 16'(r));
      chk({tag, ".off"}, 16'(lmsm_off_rd), 16'(o));
      chk({tag, ".last"}, 16'(lmsm_last_rd), 16'(l));
      chk({tag, ".stall_id"}, 16'(stall_id), 16'(sid));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".instr"}, instr_rd, 16'h0);
      chk({tag, ".pc"}, pc_rd, 16'h0);
      chk({tag, ".npc"}, npc_rd, 16'h0);
      chk({tag, ".valid"}, 16'(valid_rd), 16'd0);
      chk({tag, ".lmsm"}, 16'(lmsm_rd), 16'd0);
      chk({tag, ".reg"}, 16'(lmsm_reg_rd), 16'd0);
      chk({tag, ".off"}, 16'(lmsm_off_rd), 16'd0);
      chk({tag, ".last"}, 16'(lmsm_last_rd), 16'd0);
   endtask

   initial begin
      rst = 1'b1; stall_rd = 1'b0; flush = 1'b0;
      drive(16'h0000, 16'h0000, 1'b0);
      step();
      step();
      chk_zero("reset");
      chk("reset.stall_id", 16'(stall_id), 16'd0);
      rst = 1'b0;

      // Plain ADD
      drive(16'h0000, 16'h0010, 1'b1);
      step();
      chk("add.valid", 16'(valid_rd), 16'd1);
      chk("add.instr", instr_rd, 16'h0000);
      chk("add.pc", pc_rd, 16'h0010);
      chk("add.npc", npc_rd, 16'h0011);
      chk("add.lmsm", 16'(lmsm_rd), 16'd0);
      chk("add.stall_id", 16'(stall_id), 16'd0);

      // LM mask 0x29 -> R0, R3, R5
      drive(16'h6029, 16'h0020, 1'b1);
      step();
      chk_uop("lm29.0", 3'd0, 3'd0, 1'b0, 1'b1);
      chk("lm29.0.pc", pc_rd, 16'h0020);
      drive(16'h1234, 16'h0030, 1'b1);
      step();
      chk_uop("lm29.1", 3'd3, 3'd1, 1'b0, 1'b1);
      chk("lm29.1.instr", instr_rd, 16'h6029);
      chk("lm29.1.pc", pc_rd, 16'h0020);
      chk("lm29.1.npc", npc_rd, 16'h0021);
      step();
      chk_uop("lm29.2", 3'd5, 3'd2, 1'b1, 1'b0);
      chk("lm29.2.instr", instr_rd, 16'h6029);
      step();
      chk("next.instr", instr_rd, 16'h1234);
      chk("next.pc", pc_rd, 16'h0030);
      chk("next.valid", 16'(valid_rd), 16'd1);
      chk("next.lmsm", 16'(lmsm_rd), 16'd0);

      // SM with empty mask, then SM with only R7
      drive(16'h7000, 16'h0040, 1'b1);
      step();
      chk("sm00.valid", 16'(valid_rd), 16'd0);
      chk("sm00.stall_id", 16'(stall_id), 16'd0);
      drive(16'h7080, 16'h0041, 1'b1);
      step();
      chk_uop("sm80", 3'd7, 3'd0, 1'b1, 1'b0);
      chk("sm80.pc", pc_rd, 16'h0041);

      // LM 0xFF with 2-cycle stall after the 3rd micro-op
      drive(16'h60FF, 16'h0050, 1'b1);
      step();
      chk_uop("lmff.0", 3'd0, 3'd0, 1'b0, 1'b1);
      drive(16'h0000, 16'h0060, 1'b0);
      step();
      chk_uop("lmff.1", 3'd1, 3'd1, 1'b0, 1'b1);
      step();
      chk_uop("lmff.2", 3'd2, 3'd2, 1'b0, 1'b1);
      stall_rd = 1'b1;
      step();
      chk_uop("lmff.hold0", 3'd2, 3'd2, 1'b0, 1'b1);
      step();
      chk_uop("lmff.hold1", 3'd2, 3'd2, 1'b0, 1'b1);
      stall_rd = 1'b0;
      for (int i = 3; i < 8; i++) begin
         step();
         chk_uop($sformatf("lmff.%0d", i), 3'(i), 3'(i),
                 (i == 7), (i != 7));
         chk($sformatf("lmff.%0d.pc", i), pc_rd, 16'h0050);
      end
      step();
      chk("lmff.after.valid", 16'(valid_rd), 16'd0);
      chk("lmff.after.stall_id", 16'(stall_id), 16'd0);

      // LM 0x0F flushed on the 2nd micro-op cycle
      drive(16'h600F, 16'h0070, 1'b1);
      step();
      chk_uop("lm0f.0", 3'd0, 3'd0, 1'b0, 1'b1);
      drive(16'h0000, 16'h0000, 1'b0);
      step();
      chk_uop("lm0f.1", 3'd1, 3'd1, 1'b0, 1'b1);
      flush = 1'b1;
      step();
      chk("flush.valid", 16'(valid_rd), 16'd0);
      chk("flush.lmsm", 16'(lmsm_rd), 16'd0);
      chk("flush.last", 16'(lmsm_last_rd), 16'd0);
      chk("flush.stall_id", 16'(stall_id), 16'd0);
      flush = 1'b0;
      step();
      chk("flush.n1.valid", 16'(valid_rd), 16'd0);
      step();
      chk("flush.n2.valid", 16'(valid_rd), 16'd0);

      // LM 0x0F hit by reset together with stall and flush
      drive(16'h600F, 16'h0080, 1'b1);
      step();
      chk_uop("rst0f.0", 3'd0, 3'd0, 1'b0, 1'b1);
      drive(16'h0000, 16'h0000, 1'b0);
      step();
      chk_uop("rst0f.1", 3'd1, 3'd1, 1'b0, 1'b1);
      rst = 1'b1; stall_rd = 1'b1; flush = 1'b1;
      step();
      chk_zero("midrst");
      rst = 1'b0; stall_rd = 1'b0; flush = 1'b0;
      #1;
      chk("midrst.stall_id", 16'(stall_id), 16'd0);
      step();
      chk("midrst.n1.valid", 16'(valid_rd), 16'd0);
      chk("midrst.n1.stall_id", 16'(stall_id), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
